// File: rtl/uart_word_tx.sv
// Transmit-only UART for multi-byte words: write-side FIFO, baud timer and byte framing.
// Each popped word is sent byte by byte; byte order, parity and stop bits are set by parameters.
`timescale 1ns/1ps
module uart_word_tx #(
    parameter int WORD_BYTES     = 4,
    parameter int FIFO_ADDR      = 9,
    parameter int BIT_CYCLES     = 1250,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int MSB_BYTE_FIRST = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    input  logic                    wr_en,
    output logic                    full,
    output logic [FIFO_ADDR:0]      level,
    output logic                    overflow,
    output logic                    busy,
    output logic                    tx
);

    localparam int W        = 8 * WORD_BYTES;
    localparam int DEPTH    = 1 << FIFO_ADDR;
    localparam int STOP_LEN = STOP_BITS * BIT_CYCLES;
    localparam int CW       = $clog2(STOP_LEN + 1);
    localparam int IW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bitn_q, bitn_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [W-1:0]           word_q, word_d;
    logic [7:0]             byte_q, byte_d;
    logic                   tx_q, tx_d;
    logic [FIFO_ADDR-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_ADDR:0]     level_q, level_d;
    logic                   full_q, full_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic [W-1:0]           mem_q [DEPTH];
    logic                   pop, wr_acc, last;
    logic [CW-1:0]          lim;

    function automatic logic [7:0] pick_byte(input logic [W-1:0] w, input int i);
        int sel;
        sel = (MSB_BYTE_FIRST != 0) ? (WORD_BYTES - 1 - i) : i;
        return w[8*sel +: 8];
    endfunction

    function automatic logic parity_bit(input logic [7:0] b);
        return (^b) ^ (PARITY == 1);
    endfunction

    // STOP holds for all stop bits in one pass; every other state lasts one bit time
    assign lim  = (state_q == STOP) ? CW'(STOP_LEN - 1) : CW'(BIT_CYCLES - 1);
    assign last = (cnt_q == lim);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bitn_d  = bitn_q;
        idx_d   = idx_q;
        word_d  = word_q;
        byte_d  = byte_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    word_d  = mem_q[rptr_q];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                idx_d   = '0;
                byte_d  = pick_byte(word_q, 0);
                state_d = START;
            end
            START: if (last) begin
                cnt_d   = '0;
                bitn_d  = '0;
                state_d = DATA;
            end
            DATA: if (last) begin
                cnt_d = '0;
                if (bitn_q == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
                else                bitn_d  = bitn_q + 3'd1;
            end
            PAR: if (last) begin
                cnt_d   = '0;
                state_d = STOP;
            end
            STOP: if (last) begin
                cnt_d = '0;
                if (idx_q != IW'(WORD_BYTES - 1)) begin
                    idx_d   = idx_q + IW'(1);
                    byte_d  = pick_byte(word_q, int'(idx_q) + 1);
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered line level follows the state being entered, so tx never glitches
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bitn_d];
            PAR:     tx_d = parity_bit(byte_d);
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_acc  = wr_en & ~full_q;
        wptr_d  = wptr_q + FIFO_ADDR'(wr_acc);
        rptr_d  = rptr_q + FIFO_ADDR'(pop);
        level_d = level_q + (FIFO_ADDR+1)'(wr_acc) - (FIFO_ADDR+1)'(pop);
        full_d  = (level_d == (FIFO_ADDR+1)'(DEPTH));
        ovf_d   = wr_en & full_q;
        busy_d  = (state_q != IDLE) || (level_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    // Data-only storage needs no reset; control state decides when it is used
    always_ff @(posedge clk) begin
        word_q <= word_d;
        byte_q <= byte_d;
        if (wr_acc) mem_q[wptr_q] <= wr_data;
    end

    assign tx       = tx_q;
    assign full     = full_q;
    assign level    = level_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three parameter sets share one stimulus; each is checked every
// cycle against a bit-stream model of its FIFO and serial frames, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int NI = 3;
    localparam logic [23:0] WB_T = {8'd2, 8'd4, 8'd4};
    localparam logic [23:0] FA_T = {8'd2, 8'd3, 8'd2};
    localparam logic [23:0] BC_T = {8'd3, 8'd4, 8'd4};
    localparam logic [23:0] PA_T = {8'd1, 8'd2, 8'd0};
    localparam logic [23:0] SB_T = {8'd1, 8'd2, 8'd1};
    localparam logic [23:0] MS_T = {8'd0, 8'd1, 8'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;

    logic       tx_w [NI];
    logic       full_w [NI];
    logic       ovf_w [NI];
    logic       busy_w [NI];
    logic [7:0] lvl_w [NI];

    int checks = 0;
    int errors = 0;

    logic tr_tx [NI][200];
    logic tr_busy [NI][200];
    logic [7:0] tr_lvl [8];
    logic tr_full [8];
    logic tr_ovf [8];

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < NI; g++) begin : gi
            localparam int WB    = int'(WB_T[8*g +: 8]);
            localparam int FA    = int'(FA_T[8*g +: 8]);
            localparam int BC    = int'(BC_T[8*g +: 8]);
            localparam int PA    = int'(PA_T[8*g +: 8]);
            localparam int STOPB = int'(SB_T[8*g +: 8]);
            localparam int MS    = int'(MS_T[8*g +: 8]);
            localparam int DEPTH = 1 << FA;

            logic [FA:0] lvl;
            logic tx_o, full_o, ovf_o, busy_o;

            uart_word_tx #(
                .WORD_BYTES(WB), .FIFO_ADDR(FA), .BIT_CYCLES(BC),
                .PARITY(PA), .STOP_BITS(STOPB), .MSB_BYTE_FIRST(MS)
            ) dut (
                .clk(clk), .reset(rst), .wr_data(wr_data[8*WB-1:0]), .wr_en(wr_en),
                .full(full_o), .level(lvl), .overflow(ovf_o), .busy(busy_o), .tx(tx_o)
            );

            assign tx_w[g]   = tx_o;
            assign full_w[g] = full_o;
            assign ovf_w[g]  = ovf_o;
            assign busy_w[g] = busy_o;
            assign lvl_w[g]  = 8'(lvl);

            // Model: queued words plus the exact per-cycle line level still owed
            logic [31:0] fifo[$];
            bit          stream[$];
            logic e_tx = 1'b1, e_full = 1'b0, e_ovf = 1'b0, e_busy = 1'b0;
            int   e_lvl = 0;

            task automatic gen_word(input logic [31:0] w);
                logic [7:0] b;
                stream.push_back(1'b1);
                for (int i = 0; i < WB; i++) begin
                    b = w[8*((MS != 0) ? (WB - 1 - i) : i) +: 8];
                    repeat (BC) stream.push_back(1'b0);
                    for (int j = 0; j < 8; j++) repeat (BC) stream.push_back(b[j]);
                    if (PA != 0) repeat (BC) stream.push_back((^b) ^ (PA == 1));
                    repeat (STOPB * BC) stream.push_back(1'b1);
                end
                stream.push_back(1'b1);
            endtask

            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo.delete();
                    stream.delete();
                    e_tx = 1'b1; e_full = 1'b0; e_ovf = 1'b0; e_busy = 1'b0; e_lvl = 0;
                end else begin
                    bit fullp, busyn;
                    fullp  = (fifo.size() == DEPTH);
                    busyn  = (stream.size() != 0) || (fifo.size() != 0);
                    e_ovf  = wr_en && fullp;
                    if (stream.size() == 0 && fifo.size() != 0) gen_word(fifo.pop_front());
                    if (wr_en && !fullp) fifo.push_back(wr_data);
                    e_tx   = (stream.size() != 0) ? stream.pop_front() : 1'b1;
                    e_lvl  = fifo.size();
                    e_full = (fifo.size() == DEPTH);
                    e_busy = busyn;
                end
            end

            always @(negedge clk) begin
                check($sformatf("tx%0d", g),    32'(tx_o),   32'(e_tx));
                check($sformatf("level%0d", g), 32'(lvl),    32'(e_lvl));
                check($sformatf("full%0d", g),  32'(full_o), 32'(e_full));
                check($sformatf("ovf%0d", g),   32'(ovf_o),  32'(e_ovf));
                check($sformatf("busy%0d", g),  32'(busy_o), 32'(e_busy));
            end
        end
    endgenerate

    // Inputs change only at negedges; returns just after the accepting edge
    task automatic put(input logic [31:0] w);
        wr_data = w;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((busy_w[0] | busy_w[1] | busy_w[2]) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < maxc), 32'd1);
    endtask

    task automatic trace();
        for (int t = 0; t < 200; t++) begin
            for (int g = 0; g < NI; g++) begin
                tr_tx[g][t]   = tx_w[g];
                tr_busy[g][t] = busy_w[g];
            end
            @(negedge clk);
        end
    endtask

    task automatic lit(input string nm, input logic act, input logic exp);
        check(nm, 32'(act), 32'(exp));
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        lit("rst_tx", tx_w[0], 1'b1);
        check("rst_level", 32'(lvl_w[0]), 32'd0);
        lit("rst_busy", busy_w[1], 1'b0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word; three framings see D4,C3,B2,A1 / A1..D4 / D4,C3
        put(32'hA1B2C3D4);
        trace();
        lit("w1_i0_load", tr_tx[0][1], 1'b1);
        lit("w1_i0_start", tr_tx[0][2], 1'b0);
        lit("w1_i0_b0", tr_tx[0][6], 1'b0);
        lit("w1_i0_b2", tr_tx[0][14], 1'b1);
        lit("w1_i0_b7", tr_tx[0][34], 1'b1);
        lit("w1_i0_stop", tr_tx[0][38], 1'b1);
        lit("w1_i0_start2", tr_tx[0][42], 1'b0);
        lit("w1_i0_c3b0", tr_tx[0][46], 1'b1);
        lit("w1_i0_busy162", tr_busy[0][162], 1'b1);
        lit("w1_i0_busy163", tr_busy[0][163], 1'b0);
        lit("w1_i1_a1b0", tr_tx[1][6], 1'b1);
        lit("w1_i1_a1b1", tr_tx[1][10], 1'b0);
        lit("w1_i1_a1par", tr_tx[1][38], 1'b1);
        lit("w1_i1_stop2", tr_tx[1][49], 1'b1);
        lit("w1_i1_start2", tr_tx[1][50], 1'b0);
        lit("w1_i1_b2b0", tr_tx[1][54], 1'b0);
        lit("w1_i1_d4par", tr_tx[1][182], 1'b0);
        lit("w1_i1_d4stop", tr_tx[1][193], 1'b1);
        lit("w1_i1_busy194", tr_busy[1][194], 1'b1);
        lit("w1_i1_busy195", tr_busy[1][195], 1'b0);
        lit("w1_i2_start", tr_tx[2][2], 1'b0);
        lit("w1_i2_b2", tr_tx[2][11], 1'b1);
        lit("w1_i2_oddpar", tr_tx[2][29], 1'b1);
        lit("w1_i2_stop", tr_tx[2][34], 1'b1);
        lit("w1_i2_start2", tr_tx[2][35], 1'b0);
        lit("w1_i2_c3b0", tr_tx[2][38], 1'b1);
        wait_idle(2000);

        // Byte 0x01 parity: even gives 1, odd gives 0
        put(32'h01000001);
        trace();
        lit("p01_i1_even", tr_tx[1][38], 1'b1);
        lit("p01_i2_odd", tr_tx[2][29], 1'b0);
        lit("p01_i0_stop", tr_tx[0][38], 1'b1);
        wait_idle(2000);

        // Six back-to-back writes: fill, overflow, write+pop at level 1
        for (int i = 0; i < 6; i++) begin
            wr_data = $urandom;
            wr_en   = 1'b1;
            @(negedge clk);
            tr_lvl[i] = lvl_w[0]; tr_full[i] = full_w[0]; tr_ovf[i] = ovf_w[0];
        end
        wr_en = 1'b0;
        @(negedge clk);
        tr_lvl[6] = lvl_w[0]; tr_full[6] = full_w[0]; tr_ovf[6] = ovf_w[0];
        check("fill_lvl0", 32'(tr_lvl[0]), 32'd1);
        check("fill_lvl1_wrpop", 32'(tr_lvl[1]), 32'd1);
        check("fill_lvl4", 32'(tr_lvl[4]), 32'd4);
        check("fill_lvl5", 32'(tr_lvl[5]), 32'd4);
        lit("fill_full3", tr_full[3], 1'b0);
        lit("fill_full4", tr_full[4], 1'b1);
        lit("fill_ovf4", tr_ovf[4], 1'b0);
        lit("fill_ovf5", tr_ovf[5], 1'b1);
        lit("fill_ovf6", tr_ovf[6], 1'b0);
        check("fill_i1_lvl", 32'(lvl_w[1]), 32'd5);
        wait_idle(5000);

        // Reset in the middle of byte 2 of the first of two words
        put(32'h11223344);
        put(32'h55667788);
        repeat (99) @(negedge clk);
        check("pre_rst_level", 32'(lvl_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            lit($sformatf("async_rst_tx%0d", g), tx_w[g], 1'b1);
            check($sformatf("async_rst_lvl%0d", g), 32'(lvl_w[g]), 32'd0);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        put(32'h5A3C0FF0);
        @(negedge clk);
        lit("post_rst_load", tx_w[0], 1'b1);
        @(negedge clk);
        lit("post_rst_start", tx_w[0], 1'b0);
        wait_idle(2000);

        // Random traffic: sparse, then dense enough to overflow and wrap pointers
        for (int c = 0; c < 6000; c++) begin
            wr_en   = ($urandom_range(0, 99) < 2);
            wr_data = $urandom;
            @(negedge clk);
        end
        for (int c = 0; c < 600; c++) begin
            wr_en   = ($urandom_range(0, 99) < 30);
            wr_data = $urandom;
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle(8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
